// File: rtl/dlfloat_pkg.sv
// ---------------------------------------------------------------------------
// dlfloat_pkg
// Shared definitions for the DLFloat multiplier slice.
//   - DLFloat16 layout: 1 sign, 6 exponent (bias 31), 9 mantissa bits.
//   - dlfloat_t : packed sign/exp/mant view of a 16-bit DLFloat word.
//   - mul_tag_t : requester tag that travels alongside a multiplier operation.
//   - Helpers for classifying operands (NaN, zero).
// No ports (package).
// ---------------------------------------------------------------------------
package dlfloat_pkg;

  localparam int DLF_W      = 16;
  localparam int DLF_EXP_W  = 6;
  localparam int DLF_MANT_W = 9;
  localparam int DLF_BIAS   = 31;

  // Tag ids are sized for the largest supported requester count (8).
  localparam int MAX_NREQ = 8;
  localparam int TAG_ID_W = $clog2(MAX_NREQ);

  typedef struct packed {
    logic                  sign;
    logic [DLF_EXP_W-1:0]  exp;
    logic [DLF_MANT_W-1:0] mant;
  } dlfloat_t;

  localparam logic [DLF_W-1:0] DLF_ZERO = 16'h0000;
  localparam logic [DLF_W-1:0] DLF_NAN  = 16'hFFFF;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } mul_tag_t;

  // All-ones exponent and mantissa is the only NaN pattern; DLFloat has no infinities.
  function automatic logic dlfIsNan(input dlfloat_t x);
    return (x.exp == '1) && (x.mant == '1);
  endfunction

  // DLFloat has no subnormals, so a zero exponent means the value is zero.
  function automatic logic dlfIsZero(input dlfloat_t x);
    return (x.exp == '0);
  endfunction

endpackage

// File: rtl/dlfloat_mult.sv
// ---------------------------------------------------------------------------
// dlfloat_mult
// DLFloat16 multiplier with one register stage on the output (latency 1).
// Mantissa product is truncated; NaN propagates; zero exponent flushes to zero;
// exponent underflow flushes to zero, overflow saturates to the largest finite.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   a_i    : operand a
//   b_i    : operand b
//   c_o    : registered product
// ---------------------------------------------------------------------------
module dlfloat_mult
  import dlfloat_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DLF_W-1:0] a_i,
  input  logic [DLF_W-1:0] b_i,
  output logic [DLF_W-1:0] c_o
);

  dlfloat_t               opA;
  dlfloat_t               opB;
  logic [19:0]            mantProd;
  logic signed [9:0]      expUnb;
  logic [DLF_MANT_W-1:0]  prodMant;
  logic                   prodSign;
  logic [DLF_W-1:0]       prod_d;
  logic [DLF_W-1:0]       prod_q;

  // Form the product: multiply the 10-bit significands, renormalise by one
  // position when the product reaches 2.0, and rebias the exponent sum.
  // Special operands are resolved before the normal path is considered.
  always_comb begin
    opA      = dlfloat_t'(a_i);
    opB      = dlfloat_t'(b_i);
    prodSign = opA.sign ^ opB.sign;
    mantProd = 20'({1'b1, opA.mant}) * 20'({1'b1, opB.mant});
    expUnb   = $signed({4'b0000, opA.exp}) + $signed({4'b0000, opB.exp})
               - 10'sd31 + $signed({9'b0, mantProd[19]});
    prodMant = mantProd[19] ? mantProd[18:10] : mantProd[17:9];
    prod_d   = DLF_ZERO;
    if (dlfIsNan(opA) || dlfIsNan(opB)) begin
      prod_d = DLF_NAN;
    end else if (dlfIsZero(opA) || dlfIsZero(opB) || (expUnb <= 0)) begin
      prod_d = DLF_ZERO;
    end else if (expUnb > 63) begin
      prod_d = {prodSign, 6'h3F, 9'h1FE};
    end else begin
      prod_d = {prodSign, expUnb[5:0], prodMant};
      if (prod_d[14:0] == 15'h7FFF) begin
        prod_d[0] = 1'b0;
      end
    end
  end

  // Output register giving the fixed single-cycle latency the arbiter expects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= DLF_ZERO;
    end else begin
      prod_q <= prod_d;
    end
  end

  assign c_o = prod_q;

endmodule

// File: rtl/dlfloat_rr_arb.sv
// ---------------------------------------------------------------------------
// dlfloat_rr_arb
// Combinational round-robin picker. The search begins one past the pointer
// and wraps; the first eligible requester wins. The pointer register lives in
// the parent so that it only advances on an actual grant.
// Ports:
//   elig_i      : per-requester eligibility
//   ptr_i       : index of the most recent winner
//   grant_o     : one-hot grant (all zero when nothing is eligible)
//   grantIdx_o  : binary index of the winner
//   anyGrant_o  : a winner exists this cycle
// ---------------------------------------------------------------------------
module dlfloat_rr_arb #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  elig_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [NREQ-1:0]  grant_o,
  output logic [IDX_W-1:0] grantIdx_o,
  output logic             anyGrant_o
);

  int               candInt;
  logic [IDX_W-1:0] cand;

  // Walk the requesters in priority order starting after the last winner;
  // once a winner is found later candidates are ignored.
  always_comb begin
    grant_o    = '0;
    grantIdx_o = '0;
    anyGrant_o = 1'b0;
    candInt    = 0;
    cand       = '0;
    for (int off = 1; off <= NREQ; off++) begin
      candInt = (int'(ptr_i) + off) % NREQ;
      cand    = IDX_W'(candInt);
      if (!anyGrant_o && elig_i[cand]) begin
        grant_o[cand] = 1'b1;
        grantIdx_o    = cand;
        anyGrant_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dlfloat_mult_arbiter.sv
// ---------------------------------------------------------------------------
// dlfloat_mult_arbiter
// Shares one external DLFloat multiplier among NREQ requesters. One operand
// pair per cycle is granted round-robin and registered onto mul_a/mul_b; the
// requester id rides a tag pipe matched to the multiplier latency and steers
// the product into that requester's response register, which is held until
// the requester takes it.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   req_valid/req_ready  : operand handshake per requester (ready = grant)
//   req_a, req_b         : operands per requester
//   rsp_valid/rsp_ready  : result handshake per requester
//   rsp_c                : held result per requester
//   mul_a, mul_b         : registered operands to the multiplier
//   mul_c                : multiplier product
//   busy                 : any operation in flight or any result held
// ---------------------------------------------------------------------------
module dlfloat_mult_arbiter
  import dlfloat_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int MULT_LAT = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ-1:0][DLF_W-1:0]  req_a,
  input  logic [NREQ-1:0][DLF_W-1:0]  req_b,
  output logic [NREQ-1:0]             rsp_valid,
  input  logic [NREQ-1:0]             rsp_ready,
  output logic [NREQ-1:0][DLF_W-1:0]  rsp_c,
  output logic [DLF_W-1:0]            mul_a,
  output logic [DLF_W-1:0]            mul_b,
  input  logic [DLF_W-1:0]            mul_c,
  output logic                        busy
);

  localparam int IDX_W  = $clog2(NREQ);
  localparam int STAGES = MULT_LAT + 1;

  logic [IDX_W-1:0]              ptr_q;
  logic [IDX_W-1:0]              ptr_d;
  logic [DLF_W-1:0]              mulA_q;
  logic [DLF_W-1:0]              mulA_d;
  logic [DLF_W-1:0]              mulB_q;
  logic [DLF_W-1:0]              mulB_d;
  mul_tag_t [STAGES-1:0]         tagPipe_q;
  mul_tag_t [STAGES-1:0]         tagPipe_d;
  logic [NREQ-1:0]               rspValid_q;
  logic [NREQ-1:0]               rspValid_d;
  logic [NREQ-1:0][DLF_W-1:0]    rspC_q;
  logic [NREQ-1:0][DLF_W-1:0]    rspC_d;

  logic [NREQ-1:0]               inFlight;
  logic [NREQ-1:0]               elig;
  logic [NREQ-1:0]               grant;
  logic [IDX_W-1:0]              grantIdx;
  logic                          anyGrant;
  logic [IDX_W-1:0]              capIdx;

  // Mark every requester that still has a tag somewhere in the pipe; together
  // with a held response this keeps each requester to one outstanding op.
  always_comb begin
    inFlight = '0;
    for (int s = 0; s < STAGES; s++) begin
      if (tagPipe_q[s].valid) begin
        inFlight[IDX_W'(tagPipe_q[s].id)] = 1'b1;
      end
    end
  end

  assign elig = req_valid & ~(inFlight | rspValid_q);

  dlfloat_rr_arb #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) uArb (
    .elig_i     (elig),
    .ptr_i      (ptr_q),
    .grant_o    (grant),
    .grantIdx_o (grantIdx),
    .anyGrant_o (anyGrant)
  );

  // Ready is suppressed while reset is asserted so no requester sees a
  // handshake that the held-in-reset registers would never act on.
  assign req_ready = grant & {NREQ{rst_n}};

  // Issue: the winner's operands go to the multiplier and its id enters the
  // tag pipe; idle cycles push zeros and an invalid tag. The tag pipe shifts
  // every cycle so its last stage lines up with the product on mul_c.
  always_comb begin
    ptr_d        = ptr_q;
    mulA_d       = '0;
    mulB_d       = '0;
    tagPipe_d    = '0;
    if (anyGrant) begin
      ptr_d              = grantIdx;
      mulA_d             = req_a[grantIdx];
      mulB_d             = req_b[grantIdx];
      tagPipe_d[0].valid = 1'b1;
      tagPipe_d[0].id    = TAG_ID_W'(grantIdx);
    end
    for (int s = 1; s < STAGES; s++) begin
      tagPipe_d[s] = tagPipe_q[s-1];
    end
  end

  assign capIdx = IDX_W'(tagPipe_q[STAGES-1].id);

  // Response slots: a consumed result clears, and a product arriving with a
  // valid tag is written into the tagged slot. Both never hit the same slot in
  // one cycle because a held or in-flight slot cannot be regranted.
  always_comb begin
    rspValid_d = rspValid_q & ~rsp_ready;
    rspC_d     = rspC_q;
    if (tagPipe_q[STAGES-1].valid) begin
      rspValid_d[capIdx] = 1'b1;
      rspC_d[capIdx]     = mul_c;
    end
  end

  // State registers. Reset discards in-flight tags so a product already in
  // the multiplier can never surface as a stale response, and parks the
  // pointer on the last index so requester 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= IDX_W'(NREQ - 1);
      mulA_q     <= '0;
      mulB_q     <= '0;
      tagPipe_q  <= '0;
      rspValid_q <= '0;
      rspC_q     <= '0;
    end else begin
      ptr_q      <= ptr_d;
      mulA_q     <= mulA_d;
      mulB_q     <= mulB_d;
      tagPipe_q  <= tagPipe_d;
      rspValid_q <= rspValid_d;
      rspC_q     <= rspC_d;
    end
  end

  assign mul_a     = mulA_q;
  assign mul_b     = mulB_q;
  assign rsp_valid = rspValid_q;
  assign rsp_c     = rspC_q;
  assign busy      = (|inFlight) | (|rspValid_q);

endmodule

// File: doc/dlfloat_mult_arbiter.md
Name: dlfloat_mult_arbiter

Overview:
- Shares one `dlfloat_mult` instance (16-bit DLFloat: 1 sign, 6 exponent, 9 mantissa; registered output) among NREQ requesters.
- Round-robin grant of one operand pair per cycle into the multiplier; the requester ID tracks the multiplier latency alongside the data.
- Each product is steered into a per-requester response register, held under valid/ready back-pressure.
- Sits between the vector/accumulate front-ends and the single shared multiplier.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MULT_LAT, 1, `dlfloat_mult` latency: clock edges from `mul_a`/`mul_b` stable to `mul_c` valid.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  [NREQ-1:0]  requester i presents an operand pair.
- req_ready  out  [NREQ-1:0]  combinational one-hot grant; handshake = valid & ready.
- req_a  in  [NREQ-1:0][15:0]  operand a per requester.
- req_b  in  [NREQ-1:0][15:0]  operand b per requester.
- rsp_valid  out  [NREQ-1:0]  result held for requester i.
- rsp_ready  in  [NREQ-1:0]  requester i consumes its result.
- rsp_c  out  [NREQ-1:0][15:0]  result per requester.
- mul_a  out  16  to multiplier input a (registered).
- mul_b  out  16  to multiplier input b (registered).
- mul_c  in  16  from multiplier output c.
- busy  out  1  any tag in flight or any rsp_valid set.

Behaviour:
- Reset, asynchronous:
  - rsp_valid=0, rsp_c=0, mul_a=0, mul_b=0.
  - Tag pipe all invalid; RR pointer=NREQ-1, so requester 0 has first priority.
  - req_ready=0, busy=0.
  - In-flight products are discarded; no stale rsp_valid after rst_n deasserts.
- Eligibility:
  - elig[i] = req_valid[i] & ~slot_busy[i].
  - slot_busy[i] = tag for i in flight OR rsp_valid[i].
  - Each requester has at most one outstanding operation.
- Arbitration:
  - Search starts at pointer+1, wrapping modulo NREQ; the first eligible index is granted.
  - req_ready is the one-hot grant, or all-zero when nothing is eligible.
  - Pointer updates to the granted index on grant only.
  - req_ready depends on req_valid; requesters must not make valid depend on ready.
- Issue, at accept edge E0:
  - mul_a/mul_b <= req_a/req_b of the winner.
  - Tag stage0 <= {valid=1, id}.
  - With no grant, mul_a/mul_b <= 0 and stage0 valid <= 0.
- Tag pipe:
  - MULT_LAT+1 stages, shifting every cycle unconditionally.
  - Final stage aligns with mul_c valid.
- Capture:
  - When the final-stage tag is valid with id k: rsp_c[k] <= mul_c and rsp_valid[k] <= 1.
  - rsp_valid[k] rises after edge E0+MULT_LAT+1 (2 edges at default).
  - Capture never collides with a held rsp_valid[k], because slot_busy blocks re-grant.
- Response:
  - rsp_valid[i]/rsp_c[i] are held stable until rsp_valid[i] & rsp_ready[i] at an edge, then rsp_valid[i] clears.
  - Requester i is eligible again from the following cycle; there is no same-cycle regrant.
- Throughput: 1 op/cycle aggregate when NREQ >= MULT_LAT+3; per-requester 1 op per MULT_LAT+3 cycles.
- Arithmetic: none locally. Operands and results pass through bit-exact; zero, subnormal and NaN handling belongs to `dlfloat_mult`.
- busy is combinational OR of tag valids and rsp_valid.

Decomposition:
- Package `dlfloat_pkg`:
  - `DLF_W`=16, `DLF_EXP_W`=6, `DLF_MANT_W`=9.
  - typedef `dlfloat_t` (packed sign/exp/mant struct).
  - Constants `DLF_ZERO`=16'h0000, `DLF_NAN`=16'hFFFF.
  - typedef `mul_tag_t` {valid, id[$clog2(NREQ)-1:0]}.
- Sub-module `dlfloat_rr_arb`: combinational round-robin picker (elig, pointer -> one-hot grant, index, any_grant). The pointer register stays in the parent.

Test Plan:
- Bench uses the real `dlfloat_mult`, MULT_LAT=1, NREQ=4.
- 1. Reset: hold rst_n=0 with req_valid=4'hF -> req_ready=0, rsp_valid=0, mul_a=mul_b=0, busy=0.
- 2. Single op: req0 a=16'h3EA3 (1.32), b=16'h4073 (2.45) accepted at E0 -> rsp_valid[0]=1 after E2, rsp_c[0]=16'h413A (3.226). Hold rsp_ready[0]=0 for 5 cycles -> value stable and req_ready[0]=0 although req_valid[0]=1.
- 3. Full load: req_valid=4'hF continuously, rsp_ready=4'hF -> grants 0,1,2,3,0,1… on consecutive edges, no idle cycle, each rsp_c correct.
- 4. Routing: req1 0x0000×0x4073 -> rsp_c[1]=0x0000; req2 0xFFFF×0x3EA3 -> rsp_c[2]=0xFFFF; req3 0x3EA3×0x4073 -> rsp_c[3]=0x413A, each in its own slot.
- 5. Back-pressure: rsp_ready[2]=0 held, others 1 -> requester 2 granted once then skipped; grants cycle among 0,1,3 until rsp_ready[2]=1.
- 6. Mid-flight reset: pulse rst_n low between E0 and E1 after accepting req0 -> rsp_valid=0 immediately. After release no rsp_valid appears, and the next grant goes to requester 0.
